// File: rtl/alu_ctrl_pkg.sv
// rtl/alu_ctrl_pkg.sv - shared opcodes, state encoding and helpers for the ALU share controller
package alu_ctrl_pkg;

  localparam int WAIT_W = 4;

  localparam logic [2:0] OP_ADD  = 3'd0;
  localparam logic [2:0] OP_SUB  = 3'd1;
  localparam logic [2:0] OP_MULT = 3'd2;
  localparam logic [2:0] OP_NAND = 3'd3;
  localparam logic [2:0] OP_DIV  = 3'd4;
  localparam logic [2:0] OP_MOD  = 3'd5;
  localparam logic [2:0] OP_LT   = 3'd6;
  localparam logic [2:0] OP_LE   = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  function automatic logic is_divmod(input logic [2:0] op);
    return (op == OP_DIV) || (op == OP_MOD);
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - two-way round-robin grant, combinational only
// The last_grant history register lives in the parent.
module rr_arb2 (
  input  logic       valid0,
  input  logic       valid1,
  input  logic       last_grant,
  output logic [1:0] grant
);

  always_comb begin
    grant = 2'b00;
    if (valid0 && valid1) begin
      grant = last_grant ? 2'b01 : 2'b10;
    end else if (valid0) begin
      grant = 2'b01;
    end else if (valid1) begin
      grant = 2'b10;
    end
  end

endmodule

// File: rtl/alu_share_ctrl.sv
// rtl/alu_share_ctrl.sv - shares one 16-bit ALU between two requesters
// Operands are latched on accept and held on the ALU until the next accept.
module alu_share_ctrl
  import alu_ctrl_pkg::*;
#(
  parameter int          MUL_WAIT = 1,
  parameter int          DIV_WAIT = 3,
  parameter logic [15:0] ERR_DATA = 16'hFFFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [2:0]  req0_op,
  input  logic [15:0] req0_a,
  input  logic [15:0] req0_b,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [2:0]  req1_op,
  input  logic [15:0] req1_a,
  input  logic [15:0] req1_b,
  output logic        resp0_valid,
  input  logic        resp0_ready,
  output logic [15:0] resp0_data,
  output logic        resp0_err,
  output logic        resp1_valid,
  input  logic        resp1_ready,
  output logic [15:0] resp1_data,
  output logic        resp1_err,
  output logic [2:0]  alu_operator,
  output logic [15:0] alu_op1,
  output logic [15:0] alu_op2,
  input  logic [15:0] alu_out
);

  state_t              state;
  logic                last_grant;
  logic                id_q;
  logic                err_q;
  logic [2:0]          op_q;
  logic [15:0]         a_q;
  logic [15:0]         b_q;
  logic [15:0]         result_q;
  logic [WAIT_W-1:0]   cnt_q;

  logic [1:0]          grant;
  logic                accept;
  logic                resp_hs;
  logic [2:0]          op_in;
  logic [15:0]         a_in;
  logic [15:0]         b_in;
  logic [WAIT_W-1:0]   wait_load;

  rr_arb2 u_arb (
    .valid0     (req0_valid),
    .valid1     (req1_valid),
    .last_grant (last_grant),
    .grant      (grant)
  );

  // Grant is only ever raised for a valid requester, so ready implies valid.
  assign req0_ready = (state == ST_IDLE) && grant[0];
  assign req1_ready = (state == ST_IDLE) && grant[1];
  assign accept     = req0_ready || req1_ready;

  assign op_in = grant[1] ? req1_op : req0_op;
  assign a_in  = grant[1] ? req1_a  : req0_a;
  assign b_in  = grant[1] ? req1_b  : req0_b;

  always_comb begin
    wait_load = '0;
    if (op_in == OP_MULT) begin
      wait_load = WAIT_W'(MUL_WAIT);
    end else if (is_divmod(op_in)) begin
      wait_load = WAIT_W'(DIV_WAIT);
    end
  end

  assign resp_hs = (state == ST_RESP) && (id_q ? resp1_ready : resp0_ready);

  assign resp0_valid  = (state == ST_RESP) && !id_q;
  assign resp1_valid  = (state == ST_RESP) && id_q;
  assign resp0_data   = result_q;
  assign resp1_data   = result_q;
  assign resp0_err    = err_q;
  assign resp1_err    = err_q;
  assign alu_operator = op_q;
  assign alu_op1      = a_q;
  assign alu_op2      = b_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ST_IDLE;
      last_grant <= 1'b1;
      id_q       <= 1'b0;
      err_q      <= 1'b0;
      op_q       <= '0;
      a_q        <= '0;
      b_q        <= '0;
      result_q   <= '0;
      cnt_q      <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            op_q  <= op_in;
            a_q   <= a_in;
            b_q   <= b_in;
            id_q  <= grant[1];
            cnt_q <= wait_load;
            state <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
          end else begin
            // A zero divisor never reaches the response; the ALU output is ignored.
            if (is_divmod(op_q) && (b_q == 16'd0)) begin
              result_q <= ERR_DATA;
              err_q    <= 1'b1;
            end else begin
              result_q <= alu_out;
              err_q    <= 1'b0;
            end
            state <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (resp_hs) begin
            last_grant <= id_q;
            state      <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_share_ctrl.sv
// tb/tb_alu_share_ctrl.sv - directed self-checking bench for alu_share_ctrl
module tb_alu_share_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req0_valid = 1'b0, req1_valid = 1'b0;
  logic        req0_ready, req1_ready;
  logic [2:0]  req0_op = '0, req1_op = '0;
  logic [15:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic        resp0_valid, resp1_valid;
  logic        resp0_ready = 1'b0, resp1_ready = 1'b0;
  logic [15:0] resp0_data, resp1_data;
  logic        resp0_err, resp1_err;
  logic [2:0]  alu_operator;
  logic [15:0] alu_op1, alu_op2;
  logic [15:0] alu_out;

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  alu_share_ctrl #(.MUL_WAIT(1), .DIV_WAIT(3), .ERR_DATA(16'hFFFF)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
    .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
    .req1_a(req1_a), .req1_b(req1_b),
    .resp0_valid(resp0_valid), .resp0_ready(resp0_ready), .resp0_data(resp0_data),
    .resp0_err(resp0_err),
    .resp1_valid(resp1_valid), .resp1_ready(resp1_ready), .resp1_data(resp1_data),
    .resp1_err(resp1_err),
    .alu_operator(alu_operator), .alu_op1(alu_op1), .alu_op2(alu_op2),
    .alu_out(alu_out)
  );

  // Reference ALU; a zero divisor yields a marker the controller must not forward.
  always_comb begin
    alu_out = 16'd0;
    case (alu_operator)
      3'd0: alu_out = alu_op1 + alu_op2;
      3'd1: alu_out = alu_op2 - alu_op1;
      3'd2: alu_out = alu_op1 * alu_op2;
      3'd3: alu_out = ~(alu_op1 & alu_op2);
      3'd4: alu_out = (alu_op2 == 16'd0) ? 16'h1234 : alu_op1 / alu_op2;
      3'd5: alu_out = (alu_op2 == 16'd0) ? 16'h1234 : alu_op1 % alu_op2;
      3'd6: alu_out = {15'd0, alu_op1 < alu_op2};
      3'd7: alu_out = {15'd0, alu_op1 <= alu_op2};
      default: alu_out = 16'd0;
    endcase
  end

  wire [72:0] all_out = {req0_ready, req1_ready, resp0_valid, resp1_valid, resp0_data,
                         resp1_data, resp0_err, resp1_err, alu_operator, alu_op1, alu_op2};

  task automatic send(input int n, input logic [2:0] op, input logic [15:0] a,
                      input logic [15:0] b, output int t_acc, output bit ok);
    ok = 1'b0;
    t_acc = -1;
    if (n == 0) begin
      req0_valid = 1'b1; req0_op = op; req0_a = a; req0_b = b;
    end else begin
      req1_valid = 1'b1; req1_op = op; req1_a = a; req1_b = b;
    end
    for (int i = 0; i < 50 && !ok; i++) begin
      #1;
      if ((n == 0 && req0_ready) || (n == 1 && req1_ready)) begin
        ok = 1'b1;
        t_acc = cyc;
      end
      @(negedge clk);
    end
    if (n == 0) req0_valid = 1'b0;
    else req1_valid = 1'b0;
  endtask

  task automatic wait_resp(input int n, output int t, output bit ok);
    ok = 1'b0;
    t = -1;
    for (int i = 0; i < 50; i++) begin
      #1;
      if ((n == 0 && resp0_valid) || (n == 1 && resp1_valid)) begin
        ok = 1'b1;
        t = cyc;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    #1;
    tests++;
    if (all_out !== 73'd0) begin
      fails++;
      $display("FAIL reset_outputs: got %h, want 0", all_out);
    end
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_contention();
    int ta, tr, t1;
    bit ok;
    @(negedge clk); rst = 1'b0;
    @(negedge clk); rst = 1'b1;
    @(negedge clk);
    resp0_ready = 1'b1; resp1_ready = 1'b1;
    req0_valid = 1'b1; req0_op = 3'd1; req0_a = 16'd2; req0_b = 16'd10;
    req1_valid = 1'b1; req1_op = 3'd2; req1_a = 16'd3; req1_b = 16'd5;
    #1;
    ta = cyc;
    tests++;
    if ({req0_ready, req1_ready} !== 2'b10) begin
      fails++;
      $display("FAIL cont_first_grant: got %b, want 10", {req0_ready, req1_ready});
    end
    @(negedge clk);
    req0_valid = 1'b0;
    wait_resp(0, tr, ok);
    tests++;
    if (!ok || tr - ta != 2 || resp0_data !== 16'd8 || req1_ready !== 1'b0) begin
      fails++;
      $display("FAIL cont_sub: ok=%0d lat=%0d data=%0d r1rdy=%b, want 1 2 8 0",
               ok, tr - ta, resp0_data, req1_ready);
    end
    t1 = -1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      #1;
      if (req1_ready) begin
        t1 = cyc;
        break;
      end
    end
    tests++;
    if (t1 - ta != 3) begin
      fails++;
      $display("FAIL cont_req1_accept: got offset %0d, want 3", t1 - ta);
    end
    @(negedge clk);
    req1_valid = 1'b0;
    wait_resp(1, tr, ok);
    tests++;
    if (!ok || tr - t1 != 3 || resp1_data !== 16'd15 || resp1_err !== 1'b0) begin
      fails++;
      $display("FAIL cont_mult: ok=%0d lat=%0d data=%0d err=%b, want 1 3 15 0",
               ok, tr - t1, resp1_data, resp1_err);
    end
    @(negedge clk);
  endtask

  task automatic test_add();
    int ta, tr;
    bit ok;
    @(negedge clk);
    resp0_ready = 1'b1;
    send(0, 3'd0, 16'd3, 16'd4, ta, ok);
    #1;
    tests++;
    if (!ok || {alu_operator, alu_op1, alu_op2} !== {3'd0, 16'd3, 16'd4}) begin
      fails++;
      $display("FAIL add_alu_exec: ok=%0d alu=%h, want %h", ok,
               {alu_operator, alu_op1, alu_op2}, {3'd0, 16'd3, 16'd4});
    end
    wait_resp(0, tr, ok);
    tests++;
    if (!ok || tr - ta != 2 || resp0_data !== 16'd7 || resp0_err !== 1'b0 ||
        resp1_valid !== 1'b0) begin
      fails++;
      $display("FAIL add_resp: ok=%0d lat=%0d data=%0d err=%b v1=%b, want 1 2 7 0 0",
               ok, tr - ta, resp0_data, resp0_err, resp1_valid);
    end
    tests++;
    if ({alu_operator, alu_op1, alu_op2} !== {3'd0, 16'd3, 16'd4}) begin
      fails++;
      $display("FAIL add_alu_resp: got %h, want %h", {alu_operator, alu_op1, alu_op2},
               {3'd0, 16'd3, 16'd4});
    end
    @(negedge clk);
    #1;
    tests++;
    if (resp0_valid !== 1'b0) begin
      fails++;
      $display("FAIL add_after_hs: resp0_valid=%b, want 0", resp0_valid);
    end
  endtask

  task automatic test_divmod();
    logic [2:0]  ops  [3] = '{3'd4, 3'd4, 3'd5};
    logic [15:0] bs   [3] = '{16'd0, 16'd7, 16'd7};
    logic [15:0] exps [3] = '{16'hFFFF, 16'd14, 16'd2};
    logic        errs [3] = '{1'b1, 1'b0, 1'b0};
    int ta, tr;
    bit ok;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      resp1_ready = 1'b1;
      send(1, ops[k], 16'd100, bs[k], ta, ok);
      wait_resp(1, tr, ok);
      tests++;
      if (!ok || tr - ta != 5 || resp1_data !== exps[k] || resp1_err !== errs[k] ||
          resp0_valid !== 1'b0) begin
        fails++;
        $display("FAIL divmod_%0d: ok=%0d lat=%0d data=%h err=%b v0=%b, want 1 5 %h %b 0",
                 k, ok, tr - ta, resp1_data, resp1_err, resp0_valid, exps[k], errs[k]);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_back_pressure();
    int ta, tr, t1;
    bit ok;
    @(negedge clk);
    resp0_ready = 1'b0;
    resp1_ready = 1'b1;
    send(0, 3'd0, 16'hFFFF, 16'd1, ta, ok);
    wait_resp(0, tr, ok);
    tests++;
    if (!ok || tr - ta != 2 || resp0_data !== 16'd0 || resp0_err !== 1'b0) begin
      fails++;
      $display("FAIL bp_wrap: ok=%0d lat=%0d data=%h err=%b, want 1 2 0000 0",
               ok, tr - ta, resp0_data, resp0_err);
    end
    req1_valid = 1'b1; req1_op = 3'd0; req1_a = 16'd1; req1_b = 16'd2;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      #1;
      tests++;
      if (resp0_valid !== 1'b1 || resp0_data !== 16'd0 || req1_ready !== 1'b0) begin
        fails++;
        $display("FAIL bp_hold_%0d: v0=%b data=%h r1rdy=%b, want 1 0000 0",
                 i, resp0_valid, resp0_data, req1_ready);
      end
    end
    resp0_ready = 1'b1;
    @(negedge clk);
    #1;
    t1 = cyc;
    tests++;
    if (req1_ready !== 1'b1 || resp0_valid !== 1'b0) begin
      fails++;
      $display("FAIL bp_next_grant: r1rdy=%b v0=%b, want 1 0", req1_ready, resp0_valid);
    end
    @(negedge clk);
    req1_valid = 1'b0;
    wait_resp(1, tr, ok);
    tests++;
    if (!ok || tr - t1 != 2 || resp1_data !== 16'd3) begin
      fails++;
      $display("FAIL bp_req1: ok=%0d lat=%0d data=%0d, want 1 2 3", ok, tr - t1, resp1_data);
    end
    @(negedge clk);
  endtask

  task automatic test_fairness();
    int seq[6];
    int n = 0;
    bit both = 1'b0;
    @(negedge clk);
    resp0_ready = 1'b1; resp1_ready = 1'b1;
    req0_valid = 1'b1; req0_op = 3'd3; req0_a = 16'h00F0; req0_b = 16'h0FF0;
    req1_valid = 1'b1; req1_op = 3'd6; req1_a = 16'd2;    req1_b = 16'd9;
    for (int i = 0; i < 60 && n < 6; i++) begin
      #1;
      if (req0_ready && req1_ready) both = 1'b1;
      if (req0_ready) begin
        seq[n] = 0; n++;
      end else if (req1_ready) begin
        seq[n] = 1; n++;
      end
      @(negedge clk);
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    tests++;
    if (n != 6 || both) begin
      fails++;
      $display("FAIL fair_count: grants=%0d both_ready=%0d, want 6 0", n, both);
    end
    for (int k = 0; k < 6; k++) begin
      tests++;
      if (k < n && seq[k] != (k % 2)) begin
        fails++;
        $display("FAIL fair_seq_%0d: got %0d, want %0d", k, seq[k], k % 2);
      end
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic test_reset_mid_exec();
    int ta, tr;
    bit ok;
    bit seen = 1'b0;
    @(negedge clk);
    resp0_ready = 1'b1; resp1_ready = 1'b1;
    send(0, 3'd4, 16'd50, 16'd5, ta, ok);
    @(negedge clk);
    #1;
    rst = 1'b0;
    #1;
    tests++;
    if (!ok || all_out !== 73'd0) begin
      fails++;
      $display("FAIL rst_mid_exec: ok=%0d outputs=%h, want 1 0", ok, all_out);
    end
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 8; i++) begin
      #1;
      if (resp0_valid || resp1_valid) seen = 1'b1;
      @(negedge clk);
    end
    tests++;
    if (seen) begin
      fails++;
      $display("FAIL rst_no_resp: a response appeared after reset, want none");
    end
    send(1, 3'd7, 16'd5, 16'd5, ta, ok);
    wait_resp(1, tr, ok);
    tests++;
    if (!ok || tr - ta != 2 || resp1_data !== 16'd1 || resp1_err !== 1'b0) begin
      fails++;
      $display("FAIL rst_then_le: ok=%0d lat=%0d data=%0d err=%b, want 1 2 1 0",
               ok, tr - ta, resp1_data, resp1_err);
    end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_contention();
    test_add();
    test_divmod();
    test_back_pressure();
    test_fairness();
    test_reset_mid_exec();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
